alu_issue_stage: RTL and testbench

//  Execute-stage sequencer between register read and the 32-bit alu.
//  - Accepts one decoded R-type operation over a valid/ready handshake.
//  - Registers the operands and maps funct to the 4-bit alu opCode.
//  - Drives the alu for one cycle, then captures out/v with SLT and overflow post-processing.
//  - Holds the result for writeback until it is consumed.

---
 rtl/alu_issue_stage_pkg.sv | 51 +++++
 rtl/alu.sv | 43 ++++
 rtl/alu_funct_decode.sv | 42 ++++
 rtl/alu_issue_stage.sv | 158 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the execute-stage issue logic: R-type funct codes,
// alu opCodes, operand-select encodings and the sequencer state encoding.
package alu_issue_stage_pkg;

    localparam int XLEN_DEF = 32;

    // MIPS R-type funct field values handled by this stage
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_XOR = 4'b0110,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010
    } aluOp_t;

    typedef enum logic {
        A_RS = 1'b0,
        A_RT = 1'b1
    } aSel_t;

    typedef enum logic [1:0] {
        B_RT    = 2'b00,
        B_RS    = 2'b01,
        B_SHAMT = 2'b10
    } bSel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu.sv
// 32-bit alu: add/sub with signed overflow flag, logic ops and shifts by b[4:0].
import alu_issue_stage_pkg::*;

module alu #(
    parameter int XLEN = XLEN_DEF
) (
    input  aluOp_t            opCode,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   out,
    output logic              v
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Select the operation; v is only meaningful for add and sub.
    always_comb begin
        out = '0;
        v   = 1'b0;
        case (opCode)
            ALU_ADD: begin
                out = sum;
                v   = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            ALU_SUB: begin
                out = diff;
                v   = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_XOR: out = a ^ b;
            ALU_SLL: out = a << b[4:0];
            ALU_SRL: out = a >> b[4:0];
            ALU_SRA: out = $signed(a) >>> b[4:0];
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_funct_decode.sv
// Combinational funct decoder: picks the alu opCode, operand sources and the
// SLT / overflow-trap / illegal qualifiers for one R-type operation.
import alu_issue_stage_pkg::*;

module alu_funct_decode (
    input  logic [5:0] funct,
    output aluOp_t     opCode,
    output aSel_t      aSel,
    output bSel_t      bSel,
    output logic       isSlt,
    output logic       ovfEn,
    output logic       illegal
);

    // Map funct to opCode and operand selects; unknown codes flag illegal.
    always_comb begin
        opCode  = ALU_ADD;
        aSel    = A_RS;
        bSel    = B_RT;
        isSlt   = 1'b0;
        ovfEn   = 1'b0;
        illegal = 1'b0;
        case (funct)
            F_ADD:  begin opCode = ALU_ADD; ovfEn = 1'b1; end
            F_ADDU: opCode = ALU_ADD;
            F_SUB:  begin opCode = ALU_SUB; ovfEn = 1'b1; end
            F_SUBU: opCode = ALU_SUB;
            F_AND:  opCode = ALU_AND;
            F_OR:   opCode = ALU_OR;
            F_XOR:  opCode = ALU_XOR;
            F_SLL:  begin opCode = ALU_SLL; aSel = A_RT; bSel = B_SHAMT; end
            F_SRL:  begin opCode = ALU_SRL; aSel = A_RT; bSel = B_SHAMT; end
            F_SRA:  begin opCode = ALU_SRA; aSel = A_RT; bSel = B_SHAMT; end
            F_SLLV: begin opCode = ALU_SLL; aSel = A_RT; bSel = B_RS; end
            F_SRLV: begin opCode = ALU_SRL; aSel = A_RT; bSel = B_RS; end
            F_SRAV: begin opCode = ALU_SRA; aSel = A_RT; bSel = B_RS; end
            F_SLT:  begin opCode = ALU_SUB; isSlt = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage sequencer: accepts one R-type op, drives the alu for a cycle
// from latched operands, then holds the post-processed result for writeback.
// XLEN must stay 32; the alu and SLT/shift handling assume a 32-bit word.
//
//  state | meaning
//  IDLE  | ready for a new operation (in_ready high unless reset/flush)
//  EXEC  | alu driven from latched operands; result captured at the edge
//  DONE  | out_valid high, outputs held until out_ready
import alu_issue_stage_pkg::*;

module alu_issue_stage #(
    parameter int XLEN    = XLEN_DEF,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [XLEN-1:0]   in_rs,
    input  logic [XLEN-1:0]   in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_tag,
    output logic              out_ovf,
    output logic              out_illegal
);

    state_t          state;
    state_t          stateNext;

    logic [5:0]      functQ;
    logic [XLEN-1:0] rsQ;
    logic [XLEN-1:0] rtQ;
    logic [4:0]      shamtQ;
    logic [4:0]      tagQ;

    aluOp_t          opCode;
    aSel_t           aSel;
    bSel_t           bSel;
    logic            isSlt;
    logic            ovfEn;
    logic            illegal;

    logic [XLEN-1:0] aluA;
    logic [XLEN-1:0] aluB;
    logic [XLEN-1:0] aluOut;
    logic            aluV;
    logic [XLEN-1:0] resultNext;
    logic            ovfNext;

    alu_funct_decode uDecode (
        .funct   (functQ),
        .opCode  (opCode),
        .aSel    (aSel),
        .bSel    (bSel),
        .isSlt   (isSlt),
        .ovfEn   (ovfEn),
        .illegal (illegal)
    );

    alu #(.XLEN(XLEN)) uAlu (
        .opCode (opCode),
        .a      (aluA),
        .b      (aluB),
        .out    (aluOut),
        .v      (aluV)
    );

    // Operand muxing from the latched registers.
    always_comb begin
        aluA = (aSel == A_RT) ? rtQ : rsQ;
        case (bSel)
            B_RS:    aluB = rsQ;
            B_SHAMT: aluB = {{(XLEN-5){1'b0}}, shamtQ};
            default: aluB = rtQ;
        endcase
    end

    // SLT takes the true signed compare (sign xor overflow); illegal ops yield zero.
    always_comb begin
        resultNext = aluOut;
        ovfNext    = aluV & ovfEn & TRAP_EN;
        if (isSlt) begin
            resultNext = {{(XLEN-1){1'b0}}, aluOut[XLEN-1] ^ aluV};
        end
        if (illegal) begin
            resultNext = '0;
            ovfNext    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake; flush and reset both block acceptance.
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~reset & ~flush;
                if (in_valid && in_ready) begin
                    stateNext = EXEC;
                end
            end
            EXEC: stateNext = DONE;
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (flush) begin
            stateNext = IDLE;
        end
    end

    // Latch the operation on the accept cycle.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            functQ <= in_funct;
            rsQ    <= in_rs;
            rtQ    <= in_rt;
            shamtQ <= in_shamt;
            tagQ   <= in_tag;
        end
    end

    // Capture the alu result at the end of EXEC; held unchanged through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_result  <= '0;
            out_tag     <= '0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (state == EXEC && !flush) begin
            out_result  <= resultNext;
            out_tag     <= tagQ;
            out_ovf     <= ovfNext;
            out_illegal <= illegal;
        end
    end

    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a reference model feeding a
// scoreboard queue; results are popped when out_valid appears.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  tag;
        logic        ovf;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_rs, in_rt, out_result;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic        out_ovf, out_illegal;

    exp_t sbQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_shamt    (in_shamt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not terminate");
    end

    // Reference behaviour written directly from the instruction semantics.
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] sh, input logic [4:0] tag);
        exp_t        e;
        logic [32:0] s;
        e.result  = 32'h0;
        e.tag     = tag;
        e.ovf     = 1'b0;
        e.illegal = 1'b0;
        case (f)
            6'h20: begin s = {rs[31], rs} + {rt[31], rt}; e.result = s[31:0]; e.ovf = s[32] ^ s[31]; end
            6'h21: e.result = rs + rt;
            6'h22: begin s = {rs[31], rs} - {rt[31], rt}; e.result = s[31:0]; e.ovf = s[32] ^ s[31]; end
            6'h23: e.result = rs - rt;
            6'h24: e.result = rs & rt;
            6'h25: e.result = rs | rt;
            6'h26: e.result = rs ^ rt;
            6'h00: e.result = rt << sh;
            6'h02: e.result = rt >> sh;
            6'h03: e.result = $signed(rt) >>> sh;
            6'h04: e.result = rt << rs[4:0];
            6'h06: e.result = rt >> rs[4:0];
            6'h07: e.result = $signed(rt) >>> rs[4:0];
            6'h2a: e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkOut(input string name, input exp_t e);
        check({name, "_result"},  out_result, e.result);
        check({name, "_tag"},     {27'b0, out_tag}, {27'b0, e.tag});
        check({name, "_ovf"},     {31'b0, out_ovf}, {31'b0, e.ovf});
        check({name, "_illegal"}, {31'b0, out_illegal}, {31'b0, e.illegal});
    endtask

    // Present one op at the current negedge; leaves the bench at the next negedge.
    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sh, input logic [4:0] tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_funct = f;
        in_rs    = rs;
        in_rt    = rt;
        in_shamt = sh;
        in_tag   = tag;
        sbQ.push_back(model(f, rs, rt, sh, tag));
        @(negedge clk);
        in_valid = 1'b0;
        in_funct = 6'($urandom);
        in_rs    = $urandom;
        in_rt    = $urandom;
        in_shamt = 5'($urandom);
        in_tag   = 5'($urandom);
    endtask

    // Wait (bounded) for out_valid, check latency and pop the expected result.
    task automatic waitResult(input string name, output exp_t e);
        int lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 32'd2);
        e = '0;
        if (sbQ.size() > 0) e = sbQ.pop_front();
        if (out_valid) checkOut(name, e);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consume_valid_low", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] sh, input logic [4:0] tag);
        exp_t e;
        issue(f, rs, rt, sh, tag);
        waitResult(name, e);
        consume();
    endtask

    initial begin
        exp_t e;
        int   k;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_funct = '0; in_rs = '0; in_rt = '0; in_shamt = '0; in_tag = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",   {31'b0, in_ready}, 32'd0);
        check("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_result",     out_result, 32'd0);
        check("rst_tag",        {27'b0, out_tag}, 32'd0);
        check("rst_ovf",        {31'b0, out_ovf}, 32'd0);
        check("rst_illegal",    {31'b0, out_illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);

        runOp("add_ovf",  6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd1);
        runOp("addu",     6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd2);
        runOp("sub",      6'h22, 32'h5, 32'h9, 5'd0, 5'd3);
        runOp("sub_ovf",  6'h22, 32'h8000_0000, 32'h1, 5'd0, 5'd4);
        runOp("subu",     6'h23, 32'h8000_0000, 32'h1, 5'd0, 5'd5);
        runOp("slt_neg",  6'h2a, 32'h8000_0000, 32'h1, 5'd0, 5'd6);
        runOp("slt_pos",  6'h2a, 32'h1, 32'h8000_0000, 5'd0, 5'd7);
        runOp("sra",      6'h03, 32'h0, 32'hF000_0000, 5'd4, 5'd8);
        runOp("sllv",     6'h04, 32'h25, 32'h1, 5'd0, 5'd9);
        runOp("srlv",     6'h06, 32'h3F, 32'h8000_0000, 5'd0, 5'd10);
        runOp("srav",     6'h07, 32'h24, 32'h8000_0000, 5'd9, 5'd11);
        runOp("sll",      6'h00, 32'hFFFF_FFFF, 32'h0000_00F3, 5'd28, 5'd12);
        runOp("srl",      6'h02, 32'h0, 32'hF000_000F, 5'd1, 5'd13);

        // Illegal funct held with out_ready low: outputs must not move.
        issue(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 5'd14);
        waitResult("illegal", e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid",   {31'b0, out_valid}, 32'd1);
            check("hold_ready",   {31'b0, in_ready}, 32'd0);
            checkOut("hold", e);
        end
        consume();

        // Flush while in EXEC: result discarded.
        in_valid = 1'b1; in_funct = 6'h21; in_rs = 32'd10; in_rt = 32'd20; in_tag = 5'd15;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_exec_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("flush_exec_ready", {31'b0, in_ready}, 32'd1);

        // Flush together with in_valid in IDLE: nothing accepted.
        in_valid = 1'b1; flush = 1'b1; in_funct = 6'h20; in_tag = 5'd16;
        #1;
        check("flush_idle_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_idle_valid", {31'b0, out_valid}, 32'd0);
        end
        check("flush_idle_ready_after", {31'b0, in_ready}, 32'd1);

        // Reset while DONE clears every output.
        issue(6'h26, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd0, 5'd17);
        waitResult("pre_rst", e);
        reset = 1'b1;
        @(negedge clk);
        check("rst_done_valid",   {31'b0, out_valid}, 32'd0);
        check("rst_done_result",  out_result, 32'd0);
        check("rst_done_tag",     {27'b0, out_tag}, 32'd0);
        check("rst_done_ovf",     {31'b0, out_ovf}, 32'd0);
        check("rst_done_illegal", {31'b0, out_illegal}, 32'd0);
        check("rst_done_ready",   {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_done_ready_after", {31'b0, in_ready}, 32'd1);

        // Back-to-back with out_ready tied high: accept every third cycle.
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                e = '0;
                if (sbQ.size() > 0) e = sbQ.pop_front();
                checkOut("b2b", e);
            end
            check("b2b_ready", {31'b0, in_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            if (in_ready) begin
                if (k < 4) begin
                    in_valid = 1'b1;
                    in_tag   = 5'(20 + k);
                    in_shamt = 5'd31;
                    case (k)
                        0: begin in_funct = 6'h24; in_rs = 32'hF0F0_1234; in_rt = 32'h0FF0_FF00; end
                        1: begin in_funct = 6'h25; in_rs = 32'hA000_0001; in_rt = 32'h0000_5500; end
                        2: begin in_funct = 6'h26; in_rs = 32'hFFFF_0000; in_rt = 32'h0F0F_0F0F; end
                        default: begin in_funct = 6'h02; in_rs = 32'h0; in_rt = 32'h8000_0000; end
                    endcase
                    sbQ.push_back(model(in_funct, in_rs, in_rt, in_shamt, in_tag));
                    k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("sb_empty", sbQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
